// File: rtl/conv_pkg.sv
// Shared word format, state encoding and geometry helpers for the
// padded-stream convolver front end.
package conv_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KERN  = 2'd1,
    IMG   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Side length of the zero-padded image; the convolver is built with n = padded_dim(N, P).
  function automatic int padded_dim(input int n, input int p);
    return n + 2 * p;
  endfunction

  // Counter width for a range, never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/conv_pad_buf.sv
// Kernel + image word store: one write port, one registered read port whose
// output register can be forced to zero in place of a memory read.
module conv_pad_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 13,
  parameter int AW    = 4
) (
  input  logic            clock,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [FP_W-1:0] i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic            i_rd_zero,
  output logic [FP_W-1:0] o_rd_data
);

  logic [FP_W-1:0] r_mem [DEPTH];
  logic [FP_W-1:0] r_rd_data;

  // Write port: contents are never cleared, every job overwrites them.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; the zero select produces padding and idle words.
  always_ff @(posedge clock) begin
    if (i_rd_zero) begin
      r_rd_data <= FP_ZERO;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conv_pad_feeder.sv
// Buffers one kernel and one raw image, then replays kernel words followed by
// the zero-padded image as a gap-free stream while sequencing the convolver reset.
module conv_pad_feeder
  import conv_pkg::*;
#(
  parameter int N = 3,
  parameter int M = 2,
  parameter int P = 1
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [FP_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [FP_W-1:0] a_out,
  output logic            a_valid,
  output logic            conv_rst,
  input  logic            conv_end,
  output logic            busy
);

  localparam int MM    = M * M;
  localparam int NN    = N * N;
  localparam int DEPTH = MM + NN;
  localparam int PD    = padded_dim(N, P);
  localparam int AW    = cnt_w(DEPTH);
  localparam int KW    = cnt_w(MM);
  localparam int RW    = cnt_w(PD);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [KW-1:0] KLAST    = KW'(MM - 1);
  localparam logic [RW-1:0] PLAST    = RW'(PD - 1);

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [KW-1:0]   r_kidx;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   r_col;
  logic            r_in_ready;
  logic            r_a_valid;
  logic            r_conv_rst;
  logic            r_busy;

  logic            w_xfer;
  logic            w_img_last;
  logic            w_issue_kern;
  logic            w_issue_img;
  logic [AW-1:0]   w_kaddr;
  logic [RW-1:0]   w_nr;
  logic [RW-1:0]   w_nc;
  int              w_rr;
  int              w_cc;
  logic            w_pad;
  logic            w_rd_zero;
  logic [AW-1:0]   w_rd_addr;
  logic [FP_W-1:0] w_rd_data;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_img_last = (r_row == PLAST) && (r_col == PLAST);

  // Decide which word appears on a_out next cycle; the read register adds the cycle.
  always_comb begin
    w_issue_kern = 1'b0;
    w_issue_img  = 1'b0;
    w_kaddr      = '0;
    w_nr         = '0;
    w_nc         = '0;
    case (r_state)
      LOAD: begin
        if (w_xfer && (r_wr_ptr == LAST_PTR)) begin
          w_issue_kern = 1'b1;
        end else begin
          w_issue_kern = 1'b0;
        end
      end
      KERN: begin
        if (r_kidx == KLAST) begin
          w_issue_img = 1'b1;
        end else begin
          w_issue_kern = 1'b1;
          w_kaddr      = AW'(r_kidx + KW'(1));
        end
      end
      IMG: begin
        if (w_img_last) begin
          w_issue_img = 1'b0;
        end else if (r_col == PLAST) begin
          w_issue_img = 1'b1;
          w_nr        = r_row + RW'(1);
          w_nc        = '0;
        end else begin
          w_issue_img = 1'b1;
          w_nr        = r_row;
          w_nc        = r_col + RW'(1);
        end
      end
      DRAIN: begin
        w_issue_img = 1'b0;
      end
      default: begin
        w_issue_img = 1'b0;
      end
    endcase
  end

  // Map the next padded coordinate to a buffer address or a forced zero.
  always_comb begin
    w_rr      = int'(w_nr) - P;
    w_cc      = int'(w_nc) - P;
    w_pad     = (w_rr < 0) || (w_rr >= N) || (w_cc < 0) || (w_cc >= N);
    w_rd_addr = w_kaddr;
    w_rd_zero = 1'b1;
    if (rst) begin
      w_rd_zero = 1'b1;
    end else if (w_issue_kern) begin
      w_rd_zero = 1'b0;
    end else if (w_issue_img && !w_pad) begin
      w_rd_zero = 1'b0;
      w_rd_addr = AW'(MM + w_rr * N + w_cc);
    end else begin
      w_rd_zero = 1'b1;
    end
  end

  // Job sequencer with registered handshake and convolver-control outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= LOAD;
      r_wr_ptr   <= '0;
      r_kidx     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_in_ready <= 1'b1;
      r_conv_rst <= 1'b1;
      r_a_valid  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            if (r_wr_ptr == LAST_PTR) begin
              r_state    <= KERN;
              r_kidx     <= '0;
              r_in_ready <= 1'b0;
              r_conv_rst <= 1'b0;
              r_a_valid  <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
            end
          end
        end
        KERN: begin
          if (r_kidx == KLAST) begin
            r_state <= IMG;
            r_row   <= '0;
            r_col   <= '0;
          end else begin
            r_kidx <= r_kidx + KW'(1);
          end
        end
        IMG: begin
          if (w_img_last) begin
            r_state   <= DRAIN;
            r_a_valid <= 1'b0;
          end else begin
            r_row <= w_nr;
            r_col <= w_nc;
          end
        end
        DRAIN: begin
          if (conv_end) begin
            r_state    <= LOAD;
            r_wr_ptr   <= '0;
            r_in_ready <= 1'b1;
            r_conv_rst <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= LOAD;
          r_wr_ptr   <= '0;
          r_in_ready <= 1'b1;
          r_conv_rst <= 1'b1;
          r_a_valid  <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  conv_pad_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock     (clock),
    .i_wr_en   (w_xfer),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (w_rd_addr),
    .i_rd_zero (w_rd_zero),
    .o_rd_data (w_rd_data)
  );

  assign a_out    = w_rd_data;
  assign a_valid  = r_a_valid;
  assign in_ready = r_in_ready;
  assign conv_rst = r_conv_rst;
  assign busy     = r_busy;

endmodule
